// File: rtl/xor_frame_if.sv
// xor_frame_if: operand/result stream bundle for xor_frame_unit.
interface xor_frame_if #(parameter int WIDTH = 8, parameter int CNT_W = 4);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       mode;
  logic             last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic             parity;
  logic [CNT_W-1:0] count;
  modport master(output in_valid, A, B, mode, last, out_ready,
                 input in_ready, out_valid, Y, parity, count);
  modport slave(input in_valid, A, B, mode, last, out_ready,
                output in_ready, out_valid, Y, parity, count);
endinterface

// File: rtl/xor_frame_unit.sv
// xor_frame_unit: registered per-beat XOR/XNOR or frame XOR checksum with parity and beat count.
module xor_frame_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic         clk,
  input logic         rst_n,
  xor_frame_if.slave  bus
);
  localparam logic [0:0] IDLE = 1'b0, ACCUM = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [0:0]       state;
  logic [1:0]       frm_mode, eff_mode;
  logic [WIDTH-1:0] acc, term, acc_nxt, res, y_q;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_q;
  logic             ov_q, par_q, take, pair, done;
  assign bus.in_ready  = !ov_q || bus.out_ready;
  assign bus.out_valid = ov_q;
  assign bus.Y         = y_q;
  assign bus.parity    = par_q;
  assign bus.count     = cnt_q;
  // mode only matters on a frame's first beat; later beats reuse the latched copy
  always_comb begin
    take     = bus.in_valid && bus.in_ready;
    eff_mode = state == IDLE ? bus.mode : frm_mode;
    pair     = state == IDLE && (bus.mode == 2'b00 || bus.mode == 2'b11);
    term     = eff_mode == 2'b01 ? bus.A : bus.A ^ bus.B;
    acc_nxt  = state == IDLE ? term : acc ^ term;
    cnt_nxt  = state == IDLE ? CNT_ONE : (cnt == CNT_MAX ? cnt : cnt + CNT_ONE);
    done     = pair || bus.last;
    res      = pair ? (bus.mode == 2'b11 ? ~(bus.A ^ bus.B) : bus.A ^ bus.B) : acc_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      frm_mode <= 2'b00;
      acc      <= '0;
      cnt      <= '0;
      ov_q     <= 1'b0;
      y_q      <= '0;
      par_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (take) begin
      frm_mode <= eff_mode;
      acc      <= acc_nxt;
      cnt      <= done ? '0 : cnt_nxt;
      state    <= done ? IDLE : ACCUM;
      ov_q     <= done;
      if (done) begin
        y_q   <= res;
        par_q <= ^res;
        cnt_q <= cnt_nxt;
      end
    end else if (bus.out_ready) begin
      ov_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_xor_frame_unit.sv
// tb_xor_frame_unit: directed and random frames checked against a queue-based frame model.
module tb_xor_frame_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  bit in_frame = 1'b0;
  logic [1:0] fmode = 2'b00;
  logic [7:0] terms[$];
  logic [7:0] exp_y;
  logic [3:0] exp_cnt;
  bit exp_done;
  logic [7:0] hold_y;
  xor_frame_if #(.WIDTH(8), .CNT_W(4)) bus ();
  xor_frame_unit #(.WIDTH(8), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // frame-level reference: collect terms, fold on completion
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m, input bit l);
    logic [7:0] x;
    exp_done = 1'b0;
    if (!in_frame) fmode = m;
    if (!in_frame && (m == 2'b00 || m == 2'b11)) begin
      exp_y = m == 2'b11 ? ~(a ^ b) : a ^ b;
      exp_cnt = 4'd1;
      exp_done = 1'b1;
    end else begin
      terms.push_back(fmode == 2'b01 ? a : a ^ b);
      in_frame = 1'b1;
      if (l) begin
        x = 8'h00;
        foreach (terms[i]) x = x ^ terms[i];
        exp_y = x;
        exp_cnt = terms.size() > 15 ? 4'd15 : 4'(terms.size());
        exp_done = 1'b1;
        in_frame = 1'b0;
        terms.delete();
      end
    end
  endtask
  task automatic check_result(input string tag);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(exp_done));
    if (exp_done) begin
      check({tag, ".Y"}, 32'(bus.Y), 32'(exp_y));
      check({tag, ".parity"}, 32'(bus.parity), 32'($countones(exp_y) % 2));
      check({tag, ".count"}, 32'(bus.count), 32'(exp_cnt));
    end
  endtask
  task automatic send(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] m, input bit l);
    int k;
    bus.A = a; bus.B = b; bus.mode = m; bus.last = l; bus.in_valid = 1'b1;
    for (k = 0; k < 50 && !bus.in_ready; k++) begin
      @(posedge clk); #1;
    end
    check({tag, ".in_ready_wait"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    model(a, b, m, l);
    check_result(tag);
  endtask
  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".Y"}, 32'(bus.Y), 32'd0);
    check({tag, ".parity"}, 32'(bus.parity), 32'd0);
    check({tag, ".count"}, 32'(bus.count), 32'd0);
    in_frame = 1'b0;
    terms.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.mode = 2'b00; bus.last = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.Y", 32'(bus.Y), 32'd0);
    check("rst.count", 32'(bus.count), 32'd0);
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycle();
    send("pxor", 8'hA5, 8'h0F, 2'b00, 1'b0);
    check("pxor.lit", 32'(bus.Y), 32'hAA);
    idle_cycle();
    check("pxor.idle_valid", 32'(bus.out_valid), 32'd0);
    send("pxnor", 8'hF0, 8'h0E, 2'b11, 1'b0);
    check("pxnor.lit", 32'(bus.Y), 32'h01);
    send("acca.b1", 8'h01, 8'h77, 2'b01, 1'b0);
    send("acca.b2", 8'h02, 8'h55, 2'b00, 1'b0);
    send("acca.b3", 8'h04, 8'h33, 2'b00, 1'b1);
    check("acca.lit", 32'(bus.Y), 32'h07);
    check("acca.cnt", 32'(bus.count), 32'd3);
    idle_cycle();
    bus.out_ready = 1'b0;
    send("bp.pair", 8'($urandom), 8'($urandom), 2'b00, 1'b0);
    hold_y = exp_y;
    bus.A = 8'h3C; bus.B = 8'h00; bus.mode = 2'b00; bus.last = 1'b0; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp.in_ready", 32'(bus.in_ready), 32'd0);
      check("bp.Y_hold", 32'(bus.Y), 32'(hold_y));
    end
    bus.out_ready = 1'b1;
    #1 check("bp.release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    model(8'h3C, 8'h00, 2'b00, 1'b0);
    check_result("bp.new");
    check("bp.lit", 32'(bus.Y), 32'h3C);
    for (int f = 0; f < 25; f++) begin
      logic [1:0] m;
      int n;
      bit p;
      m = 2'($urandom_range(0, 3));
      p = m == 2'b00 || m == 2'b11;
      n = p ? 1 : int'($urandom_range(1, 6));
      for (int j = 0; j < n; j++)
        send($sformatf("rnd%0d.%0d", f, j), 8'($urandom), 8'($urandom),
             j == 0 ? m : 2'($urandom_range(0, 3)), p ? 1'($urandom) : (j == n - 1));
    end
    for (int j = 0; j < 20; j++) send("sat", 8'h11, 8'h01, j == 0 ? 2'b10 : 2'b11, j == 19);
    check("sat.lit_cnt", 32'(bus.count), 32'hF);
    check("sat.lit_Y", 32'(bus.Y), 32'h00);
    send("rmid.b1", 8'h0F, 8'h00, 2'b01, 1'b0);
    send("rmid.b2", 8'hF0, 8'h00, 2'b01, 1'b0);
    pulse_reset("rmid");
    idle_cycle();
    bus.out_ready = 1'b0;
    send("rpend", 8'h3C, 8'h00, 2'b00, 1'b0);
    pulse_reset("rpend");
    send("post", 8'h55, 8'h00, 2'b01, 1'b1);
    check("post.lit_Y", 32'(bus.Y), 32'h55);
    check("post.lit_cnt", 32'(bus.count), 32'd1);
    idle_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
